// File: rtl/fft_butterfly_cfg.sv
// fft_butterfly_cfg: pipelined radix-2 DIT complex butterfly with scaling, inverse twiddle, rounding and saturation
module fft_butterfly_cfg #(
  parameter int DATA_WIDTH    = 16,
  parameter int TWIDDLE_WIDTH = 16,
  parameter int TAG_WIDTH     = 10,
  parameter bit ROUND         = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [2*DATA_WIDTH-1:0]    i_data_a,
  input  logic [2*DATA_WIDTH-1:0]    i_data_b,
  input  logic [2*TWIDDLE_WIDTH-1:0] i_twiddle,
  input  logic                       i_scale,
  input  logic                       i_inverse,
  input  logic [TAG_WIDTH-1:0]       i_tag,
  output logic [2*DATA_WIDTH-1:0]    o_data_a_out,
  output logic [2*DATA_WIDTH-1:0]    o_data_b_out,
  output logic [TAG_WIDTH-1:0]       o_tag,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic                       o_overflow,
  input  logic                       i_ovf_clear
);
  localparam int DW = DATA_WIDTH;
  localparam int TW = TWIDDLE_WIDTH;
  localparam int PW = DW + TW + 1;
  localparam logic signed [PW-1:0] MAXV  = (PW'(1) <<< (DW - 1)) - PW'(1);
  localparam logic signed [PW-1:0] MINV  = -(PW'(1) <<< (DW - 1));
  localparam logic signed [PW-1:0] RND_M = ROUND ? (PW'(1) <<< (TW - 2)) : '0;
  localparam logic signed [PW-1:0] RND_H = PW'(ROUND);
  localparam logic signed [TW-1:0] WMAX  = {1'b0, {(TW-1){1'b1}}};
  localparam logic signed [TW-1:0] WMIN  = {1'b1, {(TW-1){1'b0}}};

  // returns {saturated, value}
  function automatic logic [DW:0] sat(input logic signed [PW-1:0] x);
    return (x > MAXV) ? {1'b1, MAXV[DW-1:0]} : (x < MINV) ? {1'b1, MINV[DW-1:0]} : {1'b0, x[DW-1:0]};
  endfunction

  function automatic logic [DW:0] fin(input logic signed [PW-1:0] x, input logic sc);
    logic signed [PW-1:0] h;
    h = (x + RND_H) >>> 1;
    return sc ? {1'b0, h[DW-1:0]} : sat(x);
  endfunction

  logic en;
  logic v1_q, v2_q, v3_q, sc1_q, inv1_q, sc2_q, po2_q, ovf_q;
  logic [2*DW-1:0] a1_q, b1_q, a2_q, p2_q, a3_q, b3_q;
  logic [2*TW-1:0] w1_q;
  logic [TAG_WIDTH-1:0] tag1_q, tag2_q, tag3_q;
  logic signed [TW-1:0] wim;
  logic signed [PW-1:0] bre, bim, wre, wimx, pre, pim, are, aim, pre2, pim2;
  logic [DW:0] sre_d, sim_d, r0_d, r1_d, r2_d, r3_d;
  logic sat3_d;

  assign en           = ~v3_q | i_ready;
  assign o_ready      = en;
  assign o_valid      = v3_q;
  assign o_data_a_out = a3_q;
  assign o_data_b_out = b3_q;
  assign o_tag        = tag3_q;
  assign o_overflow   = ovf_q;

  always_comb begin
    wim  = inv1_q ? ((w1_q[TW-1:0] == WMIN) ? WMAX : -$signed(w1_q[TW-1:0])) : $signed(w1_q[TW-1:0]);
    bre  = PW'($signed(b1_q[2*DW-1:DW]));
    bim  = PW'($signed(b1_q[DW-1:0]));
    wre  = PW'($signed(w1_q[2*TW-1:TW]));
    wimx = PW'(wim);
    pre  = (bre * wre - bim * wimx + RND_M) >>> (TW - 1);
    pim  = (bre * wimx + bim * wre + RND_M) >>> (TW - 1);
    sre_d = sat(pre);
    sim_d = sat(pim);
    are  = PW'($signed(a2_q[2*DW-1:DW]));
    aim  = PW'($signed(a2_q[DW-1:0]));
    pre2 = PW'($signed(p2_q[2*DW-1:DW]));
    pim2 = PW'($signed(p2_q[DW-1:0]));
    r0_d = fin(are + pre2, sc2_q);
    r1_d = fin(aim + pim2, sc2_q);
    r2_d = fin(are - pre2, sc2_q);
    r3_d = fin(aim - pim2, sc2_q);
    sat3_d = po2_q | r0_d[DW] | r1_d[DW] | r2_d[DW] | r3_d[DW];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      {v1_q, v2_q, v3_q, sc1_q, inv1_q, sc2_q, po2_q, ovf_q} <= '0;
      {a1_q, b1_q, a2_q, p2_q, a3_q, b3_q} <= '0;
      w1_q <= '0;
      {tag1_q, tag2_q, tag3_q} <= '0;
    end else begin
      if (en) begin
        v1_q   <= i_valid;
        a1_q   <= i_data_a;
        b1_q   <= i_data_b;
        w1_q   <= i_twiddle;
        sc1_q  <= i_scale;
        inv1_q <= i_inverse;
        tag1_q <= i_tag;
        v2_q   <= v1_q;
        a2_q   <= a1_q;
        p2_q   <= {sre_d[DW-1:0], sim_d[DW-1:0]};
        po2_q  <= sre_d[DW] | sim_d[DW];
        sc2_q  <= sc1_q;
        tag2_q <= tag1_q;
        v3_q   <= v2_q;
        a3_q   <= {r0_d[DW-1:0], r1_d[DW-1:0]};
        b3_q   <= {r2_d[DW-1:0], r3_d[DW-1:0]};
        tag3_q <= tag2_q;
      end
      ovf_q <= ~i_ovf_clear & (ovf_q | (en & v2_q & sat3_d));
    end
  end
endmodule
